mat_col_streamer: RTL and testbench

Upstream stage of the systolic-array skew feed. It accepts an MxM matrix of 8-bit elements as a row-major byte stream and buffers the whole matrix. It then drives the skew feed with one column per cycle as an 8*M-bit lane vector, followed by a fixed run of zero flush cycles so the array can drain. A one-cycle `done` pulse ends each matrix, and the block returns to loading for the next one.

---
 rtl/mat_col_streamer_if.sv | 24 ++
 rtl/mat_col_streamer.sv | 100 ++++++++++
 tb/tb_mat_col_streamer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mat_col_streamer_if.sv
// Handshake and column-bus bundle between the loader/streamer and its neighbours.
interface mat_col_streamer_if #(
    parameter int unsigned M = 3
);
    logic           in_valid;
    logic [7:0]     in_data;
    logic           in_ready;
    logic [8*M-1:0] out_data;
    logic           out_valid;
    logic           out_last;
    logic           done;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, out_data, out_valid, out_last, done
    );

    // Streamer side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, out_data, out_valid, out_last, done
    );
endinterface

// File: rtl/mat_col_streamer.sv
// Buffers an MxM byte matrix (row-major in) and replays it one column per cycle,
// followed by FLUSH zero cycles and a one-cycle done pulse.
module mat_col_streamer #(
    parameter int unsigned M     = 3,
    parameter int unsigned FLUSH = 2 * M - 2
) (
    input logic               CLK,
    input logic               RST_N,
    mat_col_streamer_if.slave bus
);
    localparam int unsigned NElem  = M * M;
    localparam int unsigned LoadW  = $clog2(NElem + 1);
    localparam int unsigned ColW   = $clog2(M + 1);
    localparam int unsigned FlushW = $clog2(FLUSH + 2);

    typedef enum logic [1:0] {StLoad, StStream, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic [LoadW-1:0]  load_cnt_q, load_cnt_d;
    logic [ColW-1:0]   col_cnt_q, col_cnt_d;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0]        buf_q [NElem];
    logic [7:0]        buf_d [NElem];

    // Next-state: element capture, counters and state transitions.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        col_cnt_d   = col_cnt_q;
        flush_cnt_d = flush_cnt_q;
        buf_d       = buf_q;
        unique case (state_q)
            StLoad: begin
                if (bus.in_valid) begin
                    // Linear row-major index equals row*M + col.
                    for (int unsigned k = 0; k < NElem; k++) begin
                        if (load_cnt_q == LoadW'(k)) buf_d[k] = bus.in_data;
                    end
                    if (load_cnt_q == LoadW'(NElem - 1)) begin
                        load_cnt_d = '0;
                        state_d    = StStream;
                    end else begin
                        load_cnt_d = load_cnt_q + LoadW'(1);
                    end
                end
            end
            StStream: begin
                if (col_cnt_q == ColW'(M - 1)) begin
                    col_cnt_d = '0;
                    state_d   = (FLUSH == 0) ? StDone : StFlush;
                end else begin
                    col_cnt_d = col_cnt_q + ColW'(1);
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushW'(FLUSH - 1)) begin
                    flush_cnt_d = '0;
                    state_d     = StDone;
                end else begin
                    flush_cnt_d = flush_cnt_q + FlushW'(1);
                end
            end
            StDone:  state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    // State, counter and buffer registers; reset also wipes the buffer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StLoad;
            load_cnt_q  <= '0;
            col_cnt_q   <= '0;
            flush_cnt_q <= '0;
            for (int unsigned k = 0; k < NElem; k++) buf_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            col_cnt_q   <= col_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            buf_q       <= buf_d;
        end
    end

    // Outputs decoded purely from registers; lane i carries A[i][col].
    always_comb begin
        bus.in_ready  = (state_q == StLoad);
        bus.out_valid = (state_q == StStream);
        bus.out_last  = (state_q == StStream) && (col_cnt_q == ColW'(M - 1));
        bus.done      = (state_q == StDone);
        bus.out_data  = '0;
        if (state_q == StStream) begin
            for (int unsigned i = 0; i < M; i++) begin
                for (int unsigned j = 0; j < M; j++) begin
                    if (col_cnt_q == ColW'(j)) bus.out_data[8*i +: 8] = buf_q[i*M + j];
                end
            end
        end
    end
endmodule

// File: tb/tb_mat_col_streamer.sv
// Self-checking bench: table vectors and random matrices on M=3/FLUSH=4,
// plus hand sequences for reset, M=4/FLUSH=0 and M=1.
module tb_mat_col_streamer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mat_col_streamer_if #(.M(3)) bus3 ();
    mat_col_streamer_if #(.M(4)) bus4 ();
    mat_col_streamer_if #(.M(1)) bus1 ();

    mat_col_streamer #(.M(3), .FLUSH(4)) u_dut3 (.CLK(clk), .RST_N(rst_n), .bus(bus3));
    mat_col_streamer #(.M(4), .FLUSH(0)) u_dut4 (.CLK(clk), .RST_N(rst_n), .bus(bus4));
    mat_col_streamer #(.M(1))            u_dut1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));

    typedef struct {
        logic [7:0]  elems [9];
        int          gap_mode;   // 0 none, 1 toggle, 2 random
        bit          junk;       // hold in_valid=1/0xFF through the output phase
        bit          b2b;        // check done-to-done spacing vs previous matrix
        logic [23:0] exp_col [3];
    } vec_t;

    vec_t vecs [4];

    function automatic logic [63:0] pack(logic rdy, logic dn, logic l, logic v, logic [31:0] d);
        return {28'd0, rdy, dn, l, v, d};
    endfunction

    function automatic logic [63:0] snap3();
        return pack(bus3.in_ready, bus3.done, bus3.out_last, bus3.out_valid, {8'd0, bus3.out_data});
    endfunction

    function automatic logic [63:0] snap4();
        return pack(bus4.in_ready, bus4.done, bus4.out_last, bus4.out_valid, bus4.out_data);
    endfunction

    function automatic logic [63:0] snap1();
        return pack(bus1.in_ready, bus1.done, bus1.out_last, bus1.out_valid, {24'd0, bus1.out_data});
    endfunction

    // Reference: column c of a row-major 3x3 matrix, lane i = A[i][c].
    function automatic logic [23:0] model_col(input logic [7:0] e [9], input int c);
        logic [23:0] r;
        for (int i = 0; i < 3; i++) r[8*i +: 8] = e[i*3 + c];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one 3x3 matrix; on return we are in the cycle after the last accept.
    task automatic load3(input logic [7:0] e [9], input int gap_mode, input bit junk);
        for (int k = 0; k < 9; k++) begin
            int gaps;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus3.in_valid = 1'b0;
                bus3.in_data  = 8'hEE;
                step();
            end
            bus3.in_valid = 1'b1;
            bus3.in_data  = e[k];
            chk("load_idle", snap3(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
            step();
        end
        bus3.in_valid = junk;
        bus3.in_data  = junk ? 8'hFF : 8'h00;
    endtask

    // Check columns, flush, done and return to LOAD; returns cycle of done.
    task automatic out3(input logic [23:0] cols [3], output int done_cyc);
        for (int c = 0; c < 3; c++) begin
            chk("column", snap3(), pack(1'b0, 1'b0, c == 2, 1'b1, {8'd0, cols[c]}));
            step();
        end
        for (int f = 0; f < 4; f++) begin
            chk("flush", snap3(), pack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
            step();
        end
        chk("done", snap3(), pack(1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        done_cyc = cyc;
        step();
        bus3.in_valid = 1'b0;
        bus3.in_data  = 8'h00;
        chk("ready_again", snap3(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  e [9];
        logic [23:0] cols [3];
        logic [31:0] c4;
        int          dcyc;
        int          prev_done;

        bus3.in_valid = 1'b0; bus3.in_data = '0;
        bus4.in_valid = 1'b0; bus4.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;

        // Vector table; expected columns written out by hand.
        for (int k = 0; k < 9; k++) begin
            vecs[0].elems[k] = 8'(k + 1);
            vecs[1].elems[k] = 8'(k + 1);
            vecs[2].elems[k] = 8'(k + 10);
        end
        vecs[3].elems = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h55, 8'hAA, 8'h10};
        vecs[0].gap_mode = 0; vecs[0].junk = 1'b0; vecs[0].b2b = 1'b0;
        vecs[0].exp_col = '{24'h070401, 24'h080502, 24'h090603};
        vecs[1].gap_mode = 1; vecs[1].junk = 1'b1; vecs[1].b2b = 1'b0;
        vecs[1].exp_col = '{24'h070401, 24'h080502, 24'h090603};
        vecs[2].gap_mode = 0; vecs[2].junk = 1'b0; vecs[2].b2b = 1'b1;
        vecs[2].exp_col = '{24'h100D0A, 24'h110E0B, 24'h120F0C};
        vecs[3].gap_mode = 0; vecs[3].junk = 1'b0; vecs[3].b2b = 1'b1;
        vecs[3].exp_col = '{24'h557FFF, 24'hAA0100, 24'h10FE80};

        // Reset values while held in reset.
        step();
        step();
        chk("rst3", snap3(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        chk("rst4", snap4(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        chk("rst1", snap1(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        bus3.in_valid = 1'b1;
        bus3.in_data  = 8'h77;
        step();
        bus3.in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Table-driven matrices, loaded back to back.
        prev_done = 0;
        for (int v = 0; v < 4; v++) begin
            load3(vecs[v].elems, vecs[v].gap_mode, vecs[v].junk);
            out3(vecs[v].exp_col, dcyc);
            if (vecs[v].b2b) chk("b2b_spacing", 64'(dcyc - prev_done), 64'd17);
            prev_done = dcyc;
        end

        // Random matrices against the reference model.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 9; k++) e[k] = 8'($urandom_range(0, 255));
            for (int c = 0; c < 3; c++) cols[c] = model_col(e, c);
            load3(e, 2, 1'($urandom_range(0, 1)));
            out3(cols, dcyc);
        end

        // Reset during column 1, then a partial load discarded by reset.
        for (int k = 0; k < 9; k++) e[k] = 8'(k + 1);
        load3(e, 0, 1'b0);
        step();
        chk("mid_col1", snap3(), pack(1'b0, 1'b0, 1'b0, 1'b1, 32'h080502));
        rst_n = 1'b0;
        #1;
        chk("rst_async", snap3(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_release", snap3(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        for (int k = 0; k < 4; k++) begin
            bus3.in_valid = 1'b1;
            bus3.in_data  = 8'hCC;
            step();
        end
        bus3.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) e[k] = 8'(8'h21 + k);
        load3(e, 0, 1'b0);
        out3('{24'h272421, 24'h282522, 24'h292623}, dcyc);

        // M=4, FLUSH=0: done directly after column 3.
        for (int k = 0; k < 16; k++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = 8'(8'h40 + k);
            step();
        end
        bus4.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) c4[8*i +: 8] = 8'(8'h40 + i*4 + c);
            chk("m4_column", snap4(), pack(1'b0, 1'b0, c == 3, 1'b1, c4));
            step();
        end
        chk("m4_done", snap4(), pack(1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        step();
        chk("m4_ready", snap4(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));

        // M=1: one element, one last column, then done.
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'h5A;
        step();
        bus1.in_valid = 1'b0;
        chk("m1_column", snap1(), pack(1'b0, 1'b0, 1'b1, 1'b1, 32'h5A));
        step();
        chk("m1_done", snap1(), pack(1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        step();
        chk("m1_ready", snap1(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
